// File: rtl/agent_pkg.sv
// Shared types and constants for the explore/exploit action agent.
package agent_pkg;

  localparam int          R_W  = 16;
  localparam int          A_W  = 9;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAP  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    UPDATE,
    DONE
  } state_e;

  // Fold a 4-bit draw onto a 0..8 bit index.
  function automatic logic [3:0] bit_sel(input logic [3:0] n);
    return (n < 4'd9) ? n : n - 4'd9;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, right shifting, stepping only when enabled.
module lfsr16
  import agent_pkg::*;
#(
  parameter logic [15:0] SEED = agent_pkg::SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value_o,
  output logic [15:0] next_o
);

  assign next_o = (value_o >> 1) ^ (value_o[0] ? TAP : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value_o <= SEED;
    else if (en)
      value_o <= next_o;
  end

endmodule

// File: rtl/agent.sv
// Reward-driven action search: keep the best action seen so far and
// propose a random or best-neighbour candidate after every reward.
module agent
  import agent_pkg::*;
#(
  parameter int          R_W  = agent_pkg::R_W,
  parameter int          A_W  = agent_pkg::A_W,
  parameter logic [15:0] SEED = agent_pkg::SEED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           v,
  input  logic [R_W-1:0] r,
  output logic [A_W-1:0] a,
  output logic           d
);

  state_e         state_q, state_d;
  logic [R_W-1:0] r_q, r_d;
  logic [R_W-1:0] best_r_q, best_r_d;
  logic [A_W-1:0] best_a_q, best_a_d;
  logic [A_W-1:0] a_q, a_d;
  logic           d_q, d_d;

  logic        lfsr_en;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_n;
  logic [3:0]  k;
  logic [A_W-1:0] cand;
  logic        unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (lfsr_en),
    .value_o (lfsr_q),
    .next_o  (lfsr_n)
  );

  assign unused_lfsr = ^{lfsr_q, lfsr_n};

  assign k = bit_sel(lfsr_n[3:0]);

  always_comb begin
    cand = lfsr_n[A_W-1:0];
    if (lfsr_n[15:12] != 4'd0)
      cand = best_a_q ^ ({{(A_W-1){1'b0}}, 1'b1} << k);
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    best_r_d = best_r_q;
    best_a_d = best_a_q;
    a_d      = a_q;
    d_d      = 1'b0;
    lfsr_en  = 1'b0;
    unique case (state_q)
      // DONE doubles as an accept slot so a held v
      // yields one transaction every three cycles.
      IDLE, DONE: begin
        state_d = IDLE;
        if (v) begin
          r_d     = r;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (r_q > best_r_q) begin
          best_r_d = r_q;
          best_a_d = a_q;
        end
        state_d = UPDATE;
      end
      UPDATE: begin
        lfsr_en = 1'b1;
        a_d     = cand;
        d_d     = 1'b1;
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      best_r_q <= '0;
      best_a_q <= '0;
      a_q      <= '0;
      d_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      best_r_q <= best_r_d;
      best_a_q <= best_a_d;
      a_q      <= a_d;
      d_q      <= d_d;
    end
  end

  assign a = a_q;
  assign d = d_q;

endmodule

// File: tb/tb_agent.sv
// Self-checking bench for agent: fixed vector table, corner sequences,
// and randomized transactions against a behavioural model.
module tb_agent;
  import agent_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic [15:0] r;
  logic [8:0]  a;
  logic        d;

  always #5 clk = ~clk;

  agent dut (
    .clk (clk),
    .rst (rst),
    .v   (v),
    .r   (r),
    .a   (a),
    .d   (d)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: best reward/action, LFSR word, current action.
  logic [15:0] m_lfsr, m_br;
  logic [8:0]  m_ba, m_a;

  task automatic m_reset();
    m_lfsr = 16'hACE1;
    m_br   = 16'd0;
    m_ba   = 9'd0;
    m_a    = 9'd0;
  endtask

  task automatic m_txn(input logic [15:0] rv);
    int kk;
    if (rv > m_br) begin
      m_br = rv;
      m_ba = m_a;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if (m_lfsr[15:12] == 4'd0) begin
      m_a = m_lfsr[8:0];
    end else begin
      kk = int'(m_lfsr[3:0]);
      if (kk >= 9) kk = kk - 9;
      m_a = m_ba ^ (9'd1 << kk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v   = 1'b0;
    r   = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // One transaction: accept, wait (bounded) for d, check, see d drop.
  task automatic do_txn(input logic [15:0] rv, input string tag);
    int n;
    @(negedge clk);
    v = 1'b1;
    r = rv;
    @(posedge clk);
    #1;
    v = 1'b0;
    r = 16'($urandom);
    m_txn(rv);
    n = 0;
    while (d !== 1'b1 && n < 6) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_a"}, a, m_a);
    chk({tag, "_best_r"}, dut.best_r_q, m_br);
    chk({tag, "_best_a"}, dut.best_a_q, m_ba);
    chk({tag, "_lfsr"}, dut.u_lfsr.value_o, m_lfsr);
    @(posedge clk);
    #1;
    chk({tag, "_d_fall"}, d, 0);
  endtask

  typedef struct {
    logic [15:0] r;
    logic [15:0] br;
    logic [8:0]  ba;
    logic [8:0]  a;
    logic [15:0] lf;
  } vec_t;

  vec_t tbl[6];

  logic       mon_en = 1'b0;
  logic [8:0] a_prev;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (d !== 1'b1) chk("a_hold", a, a_prev);
      a_prev = a;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, first, last;
    logic prev_d;
    logic [15:0] prev_br;

    tbl[0] = '{16'd100,   16'd100,   9'h000, 9'h001, 16'hE270};
    tbl[1] = '{16'd50,    16'd100,   9'h000, 9'h100, 16'h7138};
    tbl[2] = '{16'd100,   16'd100,   9'h000, 9'h008, 16'h389C};
    tbl[3] = '{16'd200,   16'd200,   9'h008, 9'h028, 16'h1C4E};
    tbl[4] = '{16'd0,     16'd200,   9'h008, 9'h027, 16'h0E27};
    tbl[5] = '{16'd65535, 16'd65535, 9'h027, 9'h02F, 16'hB313};

    rst = 1'b1;
    v   = 1'b0;
    r   = 16'd0;
    #3;
    chk("rst_a", a, 0);
    chk("rst_d", d, 0);
    chk("rst_best_r", dut.best_r_q, 0);
    chk("rst_best_a", dut.best_a_q, 0);
    chk("rst_lfsr", dut.u_lfsr.value_o, 16'hACE1);
    chk("rst_state", dut.state_q, IDLE);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].r, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_a_exp", i), a, tbl[i].a);
      chk($sformatf("tbl%0d_br_exp", i), dut.best_r_q, tbl[i].br);
      chk($sformatf("tbl%0d_ba_exp", i), dut.best_a_q, tbl[i].ba);
      chk($sformatf("tbl%0d_lf_exp", i), dut.u_lfsr.value_o, tbl[i].lf);
    end

    // v held high for 30 cycles
    do_reset();
    @(negedge clk);
    v = 1'b1;
    r = 16'd10;
    pulses = 0;
    first  = -1;
    last   = -10;
    prev_d = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (d === 1'b1) begin
        if (prev_d) chk("held_width", 2, 1);
        if (first < 0) first = i;
        else chk("held_gap", i - last, 3);
        last = i;
        pulses++;
      end
      prev_d = d;
    end
    @(negedge clk);
    v = 1'b0;
    chk("held_pulses", pulses, 10);
    chk("held_first", first, 2);
    repeat (3) @(negedge clk);

    // reset in COMPARE (ab=1) or UPDATE (ab=2)
    for (int ab = 1; ab <= 2; ab++) begin
      do_reset();
      do_txn(16'd100, "pre_abort");
      @(negedge clk);
      v = 1'b1;
      r = 16'd500;
      @(posedge clk);
      #1;
      v = 1'b0;
      if (ab == 2) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      #1;
      chk($sformatf("abort%0d_a", ab), a, 0);
      chk($sformatf("abort%0d_d", ab), d, 0);
      chk($sformatf("abort%0d_br", ab), dut.best_r_q, 0);
      chk($sformatf("abort%0d_lf", ab), dut.u_lfsr.value_o, 16'hACE1);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      do_txn(16'd100, $sformatf("post_abort%0d", ab));
      chk($sformatf("post_abort%0d_a_exp", ab), a, 9'h001);
    end

    // randomized transactions
    do_reset();
    @(negedge clk);
    a_prev  = a;
    mon_en  = 1'b1;
    prev_br = 16'd0;
    for (int i = 0; i < 101; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_txn(16'($urandom_range(0, 32767)), $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_mono", i),
          32'(dut.best_r_q >= prev_br), 1);
      prev_br = dut.best_r_q;
    end
    @(negedge clk);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
